// File: rtl/inter_delay_sequencer.sv
// Staged transfer a -> b -> c: a change on a_in starts a sequence that loads b_out
// after D1 cycles and c_out after D2 more; changes seen while busy are only counted.
module inter_delay_sequencer #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned D1    = 10,
    parameter int unsigned D2    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_in,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] c_out,
    output logic             busy,
    output logic             entry_pulse,
    output logic             exit_pulse,
    output logic [7:0]       drop_cnt
);

    localparam int unsigned MAXD = (D1 > D2) ? D1 : D2;
    localparam int unsigned CW   = $clog2(MAXD + 1);

    typedef enum logic [1:0] {IDLE, WAIT_B, WAIT_C} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_prev;
    logic             chg;

    always_comb begin
        chg = (a_in != a_prev);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // a_prev tracks a_in through reset so release never looks like a change
            a_prev      <= a_in;
            state       <= IDLE;
            cnt         <= '0;
            b_out       <= '0;
            c_out       <= '0;
            busy        <= 1'b0;
            entry_pulse <= 1'b0;
            exit_pulse  <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            a_prev      <= a_in;
            entry_pulse <= 1'b0;
            exit_pulse  <= 1'b0;

            if (state != IDLE && chg && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (chg) begin
                        cnt         <= CW'(D1 - 1);
                        entry_pulse <= 1'b1;
                        busy        <= 1'b1;
                        state       <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        // b samples a_in live at this edge, not the value that triggered entry
                        b_out <= a_in;
                        cnt   <= CW'(D2 - 1);
                        state <= WAIT_C;
                    end
                end
                WAIT_C: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        c_out      <= b_out;
                        exit_pulse <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
